// File: rtl/bomb_if.sv
// bomb_if: bundle between the player modules and bomb_scheduler.
// Signalling: drop1/drop2 are plain levels sampled once per frame; only a
// 0->1 change counts as a request. There is no ready/valid pairing. Every
// scheduler output is registered and holds for the whole frame. rej1/rej2
// are single-frame pulses.
interface bomb_if;
  logic       drop1, drop2;
  logic [9:0] user1X, user1Y, user2X, user2Y;
  logic [9:0] bomb1X, bomb1Y, bomb1XS, bomb1YS;
  logic [9:0] bomb2X, bomb2Y, bomb2XS, bomb2YS;
  logic [9:0] tile1X, tile1Y, tile2X, tile2Y;
  logic [1:0] state1, state2;
  logic       rej1, rej2;

  modport master (
    output drop1, drop2, user1X, user1Y, user2X, user2Y,
    input  bomb1X, bomb1Y, bomb1XS, bomb1YS, bomb2X, bomb2Y, bomb2XS, bomb2YS,
    input  tile1X, tile1Y, tile2X, tile2Y, state1, state2, rej1, rej2
  );

  modport slave (
    input  drop1, drop2, user1X, user1Y, user2X, user2Y,
    output bomb1X, bomb1Y, bomb1XS, bomb1YS, bomb2X, bomb2Y, bomb2XS, bomb2YS,
    output tile1X, tile1Y, tile2X, tile2Y, state1, state2, rej1, rej2
  );
endinterface

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: per-player bomb lifecycle (IDLE/ARMED/BLAST/COOLDOWN).
// Snaps drops to the 32-px grid and arbitrates same-tile drops round-robin.
// Drives the blast rectangles that the player modules use for kill checks.
// Optional macro CHAIN_REACTION_EN: an armed bomb sitting fully inside the
// other bomb's live blast detonates on the next frame.
module bomb_scheduler #(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLAST_FRAMES    = 30,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int BLAST_R         = 1,
  parameter int USER_XS         = 18,
  parameter int USER_YS         = 26
) (
  input logic   frame_clk,
  input logic   Reset,
  bomb_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, BLAST = 2'd2, COOLDOWN = 2'd3} state_t;

  localparam logic [7:0] FUSE_LD  = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0] BLAST_LD = 8'(BLAST_FRAMES - 1);
  localparam logic [7:0] COOL_LD  = 8'(COOLDOWN_FRAMES - 1);

  state_t     st [2], st_n [2];
  logic [7:0] cnt [2], cnt_n [2];
  logic [9:0] tile_x [2], tile_y [2], tile_x_n [2], tile_y_n [2];
  logic [9:0] rx [2], ry [2], rxs [2], rys [2];
  logic [9:0] rx_n [2], ry_n [2], rxs_n [2], rys_n [2];
  logic [9:0] user_x [2], user_y [2], snap_x [2], snap_y [2];
  logic       drop_now [2], drop_q [2];
  logic       req [2], occ [2], lose [2], accept [2], chain [2];
  logic       rej [2], rej_n [2];
  logic       rr, rr_n, conflict;

  // Centre of the sprite, shifted back one tile, floored to the grid.
  function automatic logic [9:0] snap(input logic [9:0] p, input logic [9:0] half);
    logic [9:0] col;
    col = (p + half - 10'd32) >> 5;
    return (col << 5) + 10'd32;
  endfunction

  // One axis of the blast rectangle: {start, size}, clipped to [32, hi].
  function automatic logic [19:0] span(input logic [9:0] t, input int hi);
    int l, r;
    l = int'(t) - 32 * BLAST_R;
    if (l < 32) l = 32;
    r = int'(t) + 32 + 32 * BLAST_R;
    if (r > hi) r = hi;
    return {10'(l), 10'(r - l)};
  endfunction

  assign drop_now[0] = bus.drop1;
  assign drop_now[1] = bus.drop2;
  assign user_x[0]   = bus.user1X;
  assign user_y[0]   = bus.user1Y;
  assign user_x[1]   = bus.user2X;
  assign user_y[1]   = bus.user2Y;

  // Next-state, counter, arbitration and rectangle logic for both players.
  always_comb begin
    rr_n = rr;
    for (int i = 0; i < 2; i++) begin
      snap_x[i] = snap(user_x[i], 10'(USER_XS / 2));
      snap_y[i] = snap(user_y[i], 10'(USER_YS / 2));
      req[i]    = drop_now[i] && !drop_q[i] && (st[i] == IDLE);
    end
    conflict = req[0] && req[1] && (snap_x[0] == snap_x[1]) && (snap_y[0] == snap_y[1]);
    if (conflict) rr_n = ~rr;
    lose[0] = conflict && rr;
    lose[1] = conflict && !rr;
    for (int i = 0; i < 2; i++) begin
      st_n[i]     = st[i];
      cnt_n[i]    = cnt[i];
      tile_x_n[i] = tile_x[i];
      tile_y_n[i] = tile_y[i];
      occ[i]      = ((st[1-i] == ARMED) || (st[1-i] == BLAST)) &&
                    (tile_x[1-i] == snap_x[i]) && (tile_y[1-i] == snap_y[i]);
      accept[i]   = req[i] && !occ[i] && !lose[i];
      rej_n[i]    = req[i] && !accept[i];
`ifdef CHAIN_REACTION_EN
      chain[i]    = (rxs[1-i] != 10'd0) && (tile_x[i] >= rx[1-i]) && (tile_y[i] >= ry[1-i]) &&
                    ({1'b0, tile_x[i]} + 11'd32 <= {1'b0, rx[1-i]} + {1'b0, rxs[1-i]}) &&
                    ({1'b0, tile_y[i]} + 11'd32 <= {1'b0, ry[1-i]} + {1'b0, rys[1-i]});
`else
      chain[i]    = 1'b0;
`endif
      case (st[i])
        IDLE: if (accept[i]) begin
          st_n[i]     = ARMED;
          cnt_n[i]    = FUSE_LD;
          tile_x_n[i] = snap_x[i];
          tile_y_n[i] = snap_y[i];
        end
        ARMED: if (cnt[i] == 8'd0 || chain[i]) begin
          st_n[i]  = BLAST;
          cnt_n[i] = BLAST_LD;
        end else cnt_n[i] = cnt[i] - 8'd1;
        BLAST: if (cnt[i] == 8'd0) begin
          st_n[i]  = COOLDOWN;
          cnt_n[i] = COOL_LD;
        end else cnt_n[i] = cnt[i] - 8'd1;
        default: if (cnt[i] == 8'd0) st_n[i] = IDLE;
                 else cnt_n[i] = cnt[i] - 8'd1;
      endcase
      if (st_n[i] == BLAST) begin
        {rx_n[i], rxs_n[i]} = span(tile_x_n[i], 576);
        {ry_n[i], rys_n[i]} = span(tile_y_n[i], 448);
      end else begin
        rx_n[i]  = 10'd0;
        rxs_n[i] = 10'd0;
        ry_n[i]  = 10'd0;
        rys_n[i] = 10'd0;
      end
    end
  end

  // State register; drop history resets high so a held key cannot drop.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      rr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        st[i]     <= IDLE;
        cnt[i]    <= 8'd0;
        tile_x[i] <= 10'd0;
        tile_y[i] <= 10'd0;
        rx[i]     <= 10'd0;
        ry[i]     <= 10'd0;
        rxs[i]    <= 10'd0;
        rys[i]    <= 10'd0;
        rej[i]    <= 1'b0;
        drop_q[i] <= 1'b1;
      end
    end else begin
      rr <= rr_n;
      for (int i = 0; i < 2; i++) begin
        st[i]     <= st_n[i];
        cnt[i]    <= cnt_n[i];
        tile_x[i] <= tile_x_n[i];
        tile_y[i] <= tile_y_n[i];
        rx[i]     <= rx_n[i];
        ry[i]     <= ry_n[i];
        rxs[i]    <= rxs_n[i];
        rys[i]    <= rys_n[i];
        rej[i]    <= rej_n[i];
        drop_q[i] <= drop_now[i];
      end
    end
  end

  assign bus.state1  = st[0];
  assign bus.state2  = st[1];
  assign bus.rej1    = rej[0];
  assign bus.rej2    = rej[1];
  assign bus.tile1X  = tile_x[0];
  assign bus.tile1Y  = tile_y[0];
  assign bus.tile2X  = tile_x[1];
  assign bus.tile2Y  = tile_y[1];
  assign bus.bomb1X  = rx[0];
  assign bus.bomb1Y  = ry[0];
  assign bus.bomb1XS = rxs[0];
  assign bus.bomb1YS = rys[0];
  assign bus.bomb2X  = rx[1];
  assign bus.bomb2Y  = ry[1];
  assign bus.bomb2XS = rxs[1];
  assign bus.bomb2YS = rys[1];
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: scoreboard bench for bomb_scheduler.
// Each scenario pushes one expected frame word per sample into exp_q. It
// then drives the drops and pops and compares each frame after the edge.
module tb_bomb_scheduler;
  localparam int FUSE = 120;
  localparam int BL   = 30;
  localparam int CD   = 15;
  localparam int W    = 126;
`ifdef CHAIN_REACTION_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif
  localparam logic [19:0] T96  = {10'd96, 10'd96};
  localparam logic [39:0] R96  = {10'd64, 10'd64, 10'd96, 10'd96};

  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  bomb_if bus ();

  bomb_scheduler #(
    .FUSE_FRAMES(FUSE), .BLAST_FRAMES(BL), .COOLDOWN_FRAMES(CD),
    .BLAST_R(1), .USER_XS(18), .USER_YS(26)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .bus(bus)
  );

  // Clock and reset
  always #5 frame_clk = ~frame_clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp_w;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] observe();
    return {bus.state1, bus.state2, bus.rej1, bus.rej2,
            bus.bomb1X, bus.bomb1Y, bus.bomb1XS, bus.bomb1YS,
            bus.bomb2X, bus.bomb2Y, bus.bomb2XS, bus.bomb2YS,
            bus.tile1X, bus.tile1Y, bus.tile2X, bus.tile2Y};
  endfunction

  // Reference lifecycle: ARMED from sample d, BLAST from sample bs.
  function automatic logic [1:0] state_at(int k, int d, int bs);
    if (d <= 0 || k < d) return 2'd0;
    if (k < bs) return 2'd1;
    if (k < bs + BL) return 2'd2;
    if (k < bs + BL + CD) return 2'd3;
    return 2'd0;
  endfunction

  task automatic push_exp(input int n, d1, bs1, d2, bs2, rj1, rj2,
                          input logic [19:0] t1o, t1n, t2o, t2n,
                          input logic [39:0] rc1, rc2);
    logic [1:0] s1, s2;
    for (int k = 1; k <= n; k++) begin
      s1 = state_at(k, d1, bs1);
      s2 = state_at(k, d2, bs2);
      exp_q.push_back({s1, s2, (k == rj1), (k == rj2),
                       (s1 == 2'd2) ? rc1 : 40'd0, (s2 == 2'd2) ? rc2 : 40'd0,
                       (d1 > 0 && k >= d1) ? t1n : t1o,
                       (d2 > 0 && k >= d2) ? t2n : t2o});
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_users(input int x1, y1, x2, y2);
    bus.user1X = 10'(x1);
    bus.user1Y = 10'(y1);
    bus.user2X = 10'(x2);
    bus.user2Y = 10'(y2);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.drop1 = 1'b0;
    bus.drop2 = 1'b0;
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.drop1 = 1'b0;
    bus.drop2 = 1'b0;
    set_users($urandom_range(0, 600), $urandom_range(0, 440), 34, 34);
    exp_q.push_back('0);
    repeat (2) step();
    got = observe();
    exp_w = exp_q.pop_front();
    n_vec++;
    if (got !== exp_w) begin
      n_err++;
      $display("FAIL reset got %h exp %h", got, exp_w);
    end
  endtask

  task automatic test_single_drop();
    do_reset();
    set_users(34, 34, 300, 300);
    push_exp(168, 1, 1 + FUSE, 0, 0, 0, 0, 20'd0, {10'd32, 10'd32}, 20'd0, 20'd0,
             {10'd32, 10'd32, 10'd64, 10'd64}, 40'd0);
    for (int k = 1; k <= 168; k++) begin
      bus.drop1 = (k == 1);
      bus.drop2 = 1'b0;
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL single_drop k=%0d got %h exp %h", k, got, exp_w);
      end
    end
  endtask

  task automatic test_held_reset();
    set_users(34, 34, 300, 300);
    bus.drop1 = 1'b1;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int k = 1; k <= 6; k++) exp_q.push_back('0);
    for (int k = 1; k <= 6; k++) begin
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL held_reset k=%0d got %h exp %h", k, got, exp_w);
      end
    end
    push_exp(3, 2, 2 + FUSE, 0, 0, 0, 0, 20'd0, {10'd32, 10'd32}, 20'd0, 20'd0,
             {10'd32, 10'd32, 10'd64, 10'd64}, 40'd0);
    for (int k = 1; k <= 3; k++) begin
      bus.drop1 = (k == 2);
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL held_rearm k=%0d got %h exp %h", k, got, exp_w);
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    set_users(98, 98, 98, 98);
    push_exp(170, 1, 1 + FUSE, 0, 0, 0, 1, 20'd0, T96, 20'd0, 20'd0, R96, 40'd0);
    push_exp(3, 0, 0, 1, 1 + FUSE, 1, 0, T96, T96, 20'd0, T96, 40'd0, R96);
    for (int k = 1; k <= 173; k++) begin
      bus.drop1 = (k == 1 || k == 171);
      bus.drop2 = (k == 1 || k == 171);
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL conflict k=%0d got %h exp %h", k, got, exp_w);
      end
    end
  endtask

  task automatic test_occupied();
    do_reset();
    set_users(98, 98, 98, 98);
    push_exp(4, 1, 1 + FUSE, 0, 0, 0, 3, 20'd0, T96, 20'd0, 20'd0, R96, 40'd0);
    for (int k = 1; k <= 4; k++) begin
      bus.drop1 = (k == 1);
      bus.drop2 = (k == 3);
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL occupied k=%0d got %h exp %h", k, got, exp_w);
      end
    end
  endtask

  task automatic test_chain();
    int bs2;
    bs2 = CHAIN ? 1 + FUSE + 1 : 21 + FUSE;
    do_reset();
    set_users(98, 98, 130, 98);
    push_exp(188, 1, 1 + FUSE, 21, bs2, 0, 0, 20'd0, T96, 20'd0, {10'd128, 10'd96},
             R96, {10'd96, 10'd64, 10'd96, 10'd96});
    for (int k = 1; k <= 188; k++) begin
      bus.drop1 = (k == 1);
      bus.drop2 = (k == 21);
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL chain k=%0d got %h exp %h", k, got, exp_w);
      end
    end
  endtask

  task automatic test_edge_clip_and_reset();
    do_reset();
    set_users(540, 410, 34, 34);
    push_exp(125, 1, 1 + FUSE, 0, 0, 0, 0, 20'd0, {10'd544, 10'd416}, 20'd0, 20'd0,
             {10'd512, 10'd384, 10'd64, 10'd64}, 40'd0);
    exp_q.push_back('0);
    for (int k = 1; k <= 126; k++) begin
      bus.drop1 = (k == 1);
      bus.drop2 = 1'b0;
      Reset = (k == 126);
      step();
      got = observe();
      exp_w = exp_q.pop_front();
      n_vec++;
      if (got !== exp_w) begin
        n_err++;
        $display("FAIL edge_clip_reset k=%0d got %h exp %h", k, got, exp_w);
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    bus.drop1 = 1'b0;
    bus.drop2 = 1'b0;
    set_users(0, 0, 0, 0);
    test_reset();
    test_single_drop();
    test_held_reset();
    test_conflict();
    test_occupied();
    test_chain();
    test_edge_clip_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
